// File: rtl/id_hazard_scheduler.sv
// id_hazard_scheduler
// In-order issue control between decode and execute. A 32-entry scoreboard
// tracks registers with pending writes. Each cycle the decode-stage
// instruction either issues, stalls fetch/decode on a RAW/WAW hazard, or is
// squashed while a control-flow redirect from execute is being flushed.
module id_hazard_scheduler #(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [6:0]  id_opcode,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic [4:0]  id_rd,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic        ex_redirect,
   output logic        issue,
   output logic        stall_fetch,
   output logic        stall_decode,
   output logic        flush,
   output logic [31:0] busy_map
);

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } schedState_t;

   localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES);

   schedState_t state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] busyMap_q, busyMap_d;

   logic        usesRs1;
   logic        usesRs2;
   logic        writesRd;
   logic [31:0] wbMask;
   logic [31:0] setMask;
   logic [31:0] effBusy;
   logic        hazard;
   logic        flushActive;

   // Decode the opcode class into which register fields are actually used.
   always_comb begin
      usesRs1  = 1'b0;
      usesRs2  = 1'b0;
      writesRd = 1'b0;
      case (id_opcode)
         7'b0110011: begin usesRs1 = 1'b1; usesRs2 = 1'b1; writesRd = 1'b1; end
         7'b0100011,
         7'b1100011: begin usesRs1 = 1'b1; usesRs2 = 1'b1; end
         7'b0010011,
         7'b0000011,
         7'b1100111: begin usesRs1 = 1'b1; writesRd = 1'b1; end
         7'b0110111,
         7'b0010111,
         7'b1101111: begin writesRd = 1'b1; end
         default:    begin end
      endcase
   end

   // A same-cycle writeback satisfies a read (write-first regfile), and x0 is never busy.
   always_comb begin
      wbMask  = wb_valid ? (32'h1 << wb_rd) : 32'h0;
      effBusy = busyMap_q & ~wbMask & ~32'h1;
      hazard  = id_valid & ((usesRs1  & effBusy[id_rs1]) |
                            (usesRs2  & effBusy[id_rs2]) |
                            (writesRd & effBusy[id_rd]));
   end

   // Issue/stall/flush decisions; a flush overrides a stall and reset forces all low.
   always_comb begin
      flushActive  = ex_redirect | (state_q == SQUASH);
      issue        = reset & id_valid & ~hazard & ~flushActive;
      stall_fetch  = reset & id_valid & hazard & ~flushActive;
      stall_decode = reset & id_valid & hazard & ~flushActive;
      flush        = reset & flushActive;
      busy_map     = busyMap_q;
   end

   // Scoreboard next state: retire clears first, then an issuing writer sets its bit.
   always_comb begin
      setMask   = (issue && writesRd && (id_rd != 5'd0)) ? (32'h1 << id_rd) : 32'h0;
      busyMap_d = ((busyMap_q & ~wbMask) | setMask) & ~32'h1;
   end

   // Squash sequencing: a redirect (re)loads the counter, leaving after the cnt==1 cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (ex_redirect) begin
               state_d = SQUASH;
               cnt_d   = FlushLoad;
            end
         end
         SQUASH: begin
            if (ex_redirect) begin
               cnt_d = FlushLoad;
            end else if (cnt_q == 3'd1) begin
               state_d = RUN;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // State, counter and scoreboard registers with synchronous active-low clear.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= RUN;
         cnt_q     <= 3'd0;
         busyMap_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busyMap_q <= busyMap_d;
      end
   end

endmodule

// File: tb/tb_id_hazard_scheduler.sv
// tb_id_hazard_scheduler
// Directed walk through the issue/stall/flush scenarios followed by a random
// run, all compared against a behavioural scoreboard model of the scheduler.
module tb_id_hazard_scheduler;

   localparam int FlushCycles = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [6:0]  id_opcode;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        ex_redirect;
   logic        issue, stall_fetch, stall_decode, flush;
   logic [31:0] busy_map;

   int checkCount = 0;
   int errorCount = 0;

   // Reference model: set of registers awaiting writeback plus remaining squash cycles.
   bit modelBusy [32];
   int squashLeft;

   localparam logic [6:0] OpR   = 7'b0110011;
   localparam logic [6:0] OpS   = 7'b0100011;
   localparam logic [6:0] OpB   = 7'b1100011;
   localparam logic [6:0] OpI   = 7'b0010011;
   localparam logic [6:0] OpLd  = 7'b0000011;
   localparam logic [6:0] OpJlr = 7'b1100111;
   localparam logic [6:0] OpLui = 7'b0110111;
   localparam logic [6:0] OpAui = 7'b0010111;
   localparam logic [6:0] OpJal = 7'b1101111;
   localparam logic [6:0] OpBad = 7'b1111111;

   id_hazard_scheduler #(.FLUSH_CYCLES(FlushCycles)) dut (
      .clock        (clock),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_opcode    (id_opcode),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rd        (id_rd),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .ex_redirect  (ex_redirect),
      .issue        (issue),
      .stall_fetch  (stall_fetch),
      .stall_decode (stall_decode),
      .flush        (flush),
      .busy_map     (busy_map)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic rstN, input logic idv, input logic [6:0] op,
                                input int rs1, input int rs2, input int rd,
                                input logic wbv, input int wbr, input logic redir);
      reset       = rstN;
      id_valid    = idv;
      id_opcode   = op;
      id_rs1      = 5'(rs1);
      id_rs2      = 5'(rs2);
      id_rd       = 5'(rd);
      wb_valid    = wbv;
      wb_rd       = 5'(wbr);
      ex_redirect = redir;
      #1;
   endtask

   function automatic void regUse(input logic [6:0] op, output bit u1, output bit u2, output bit wr);
      u1 = 0; u2 = 0; wr = 0;
      if (op == OpR || op == OpS || op == OpB) begin u1 = 1; u2 = 1; end
      if (op == OpI || op == OpLd || op == OpJlr) u1 = 1;
      if (op == OpR || op == OpI || op == OpLd || op == OpJlr ||
          op == OpLui || op == OpAui || op == OpJal) wr = 1;
   endfunction

   function automatic bit pending(input int r);
      if (r == 0) return 0;
      if (wb_valid && int'(wb_rd) == r) return 0;
      return modelBusy[r];
   endfunction

   function automatic logic [31:0] modelMap();
      logic [31:0] m = 32'h0;
      for (int i = 0; i < 32; i++) m[i] = modelBusy[i];
      return m;
   endfunction

   bit expIssue, expStall, expFlush;

   function automatic void computeExpected();
      bit u1, u2, wr, haz, fl;
      regUse(id_opcode, u1, u2, wr);
      haz = id_valid && ((u1 && pending(int'(id_rs1))) || (u2 && pending(int'(id_rs2))) ||
                         (wr && pending(int'(id_rd))));
      fl = ex_redirect || (squashLeft > 0);
      expFlush = reset && fl;
      expIssue = reset && id_valid && !haz && !fl;
      expStall = reset && id_valid && haz && !fl;
   endfunction

   // Compare all outputs mid-cycle, then advance the model across the rising edge.
   task automatic stepCycle();
      bit u1, u2, wr;
      @(negedge clock);
      computeExpected();
      checkOutput("issue", {31'h0, issue}, {31'h0, expIssue});
      checkOutput("stall_fetch", {31'h0, stall_fetch}, {31'h0, expStall});
      checkOutput("stall_decode", {31'h0, stall_decode}, {31'h0, expStall});
      checkOutput("flush", {31'h0, flush}, {31'h0, expFlush});
      checkOutput("busy_map", busy_map, modelMap());
      @(posedge clock);
      regUse(id_opcode, u1, u2, wr);
      if (!reset) begin
         for (int i = 0; i < 32; i++) modelBusy[i] = 0;
         squashLeft = 0;
      end else begin
         if (wb_valid) modelBusy[wb_rd] = 0;
         if (expIssue && wr && id_rd != 0) modelBusy[id_rd] = 1;
         if (ex_redirect) squashLeft = FlushCycles;
         else if (squashLeft > 0) squashLeft--;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus(1, 0, OpBad, 0, 0, 0, 0, 0, 0);
         stepCycle();
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) modelBusy[i] = 0;
      squashLeft = 0;

      // Reset
      applyStimulus(0, 1, OpR, 1, 2, 3, 0, 0, 1);
      stepCycle();
      stepCycle();
      checkOutput("reset busy_map", busy_map, 32'h0);

      // Dependency stall and same-cycle writeback release
      applyStimulus(1, 1, OpR, 1, 2, 5, 0, 0, 0);
      stepCycle();
      checkOutput("add x5 busy", busy_map, 32'h20);
      applyStimulus(1, 1, OpI, 5, 0, 6, 0, 0, 0);
      checkOutput("addi raw stall_decode", {31'h0, stall_decode}, 32'h1);
      checkOutput("addi raw stall_fetch", {31'h0, stall_fetch}, 32'h1);
      checkOutput("addi raw issue", {31'h0, issue}, 32'h0);
      stepCycle();
      applyStimulus(1, 1, OpI, 5, 0, 6, 1, 5, 0);
      checkOutput("addi wb bypass issue", {31'h0, issue}, 32'h1);
      stepCycle();
      checkOutput("addi x6 busy", busy_map, 32'h40);

      // lui x0 never marks x0
      applyStimulus(1, 1, OpLui, 0, 0, 0, 1, 6, 0);
      checkOutput("lui x0 issue", {31'h0, issue}, 32'h1);
      stepCycle();
      checkOutput("lui x0 map", busy_map, 32'h0);

      // sw with busy rs2 stalls
      applyStimulus(1, 1, OpR, 1, 2, 5, 0, 0, 0);
      stepCycle();
      applyStimulus(1, 1, OpS, 1, 5, 0, 0, 0, 0);
      checkOutput("sw stall", {31'h0, stall_decode}, 32'h1);
      stepCycle();

      // jal x7 with every other register busy
      for (int r = 1; r < 32; r++) begin
         if (r == 5 || r == 7) continue;
         applyStimulus(1, 1, OpLui, 0, 0, r, 0, 0, 0);
         stepCycle();
      end
      applyStimulus(1, 1, OpJal, 0, 0, 7, 0, 0, 0);
      checkOutput("jal issue", {31'h0, issue}, 32'h1);
      stepCycle();
      checkOutput("jal map", busy_map, 32'hFFFF_FFFE);
      for (int r = 1; r < 32; r++) begin
         applyStimulus(1, 0, OpBad, 0, 0, 0, 1, r, 0);
         stepCycle();
      end
      checkOutput("drain map", busy_map, 32'h0);

      // WAW stall then set-wins over same-cycle clear
      applyStimulus(1, 1, OpLui, 0, 0, 9, 0, 0, 0);
      stepCycle();
      applyStimulus(1, 1, OpI, 3, 0, 9, 0, 0, 0);
      checkOutput("waw stall", {31'h0, stall_fetch}, 32'h1);
      stepCycle();
      applyStimulus(1, 1, OpI, 3, 0, 9, 1, 9, 0);
      checkOutput("waw release", {31'h0, issue}, 32'h1);
      stepCycle();
      checkOutput("set wins", busy_map, 32'h200);
      applyStimulus(1, 0, OpBad, 0, 0, 0, 1, 9, 0);
      stepCycle();

      // Single redirect: flush for 1 + FlushCycles cycles
      applyStimulus(1, 1, OpI, 0, 0, 10, 0, 0, 1);
      checkOutput("redir flush", {31'h0, flush}, 32'h1);
      checkOutput("redir issue", {31'h0, issue}, 32'h0);
      stepCycle();
      for (int k = 0; k < FlushCycles; k++) begin
         applyStimulus(1, 1, OpI, 0, 0, 10, 0, 0, 0);
         checkOutput("squash flush", {31'h0, flush}, 32'h1);
         stepCycle();
      end
      applyStimulus(1, 0, OpBad, 0, 0, 0, 0, 0, 0);
      checkOutput("squash done", {31'h0, flush}, 32'h0);
      checkOutput("squash map", busy_map, 32'h0);

      // Back-to-back redirect extends the squash by one cycle
      applyStimulus(1, 1, OpI, 0, 0, 10, 0, 0, 1);
      stepCycle();
      applyStimulus(1, 1, OpI, 0, 0, 10, 0, 0, 1);
      stepCycle();
      for (int k = 0; k < FlushCycles; k++) begin
         applyStimulus(1, 1, OpI, 0, 0, 10, 0, 0, 0);
         checkOutput("extended flush", {31'h0, flush}, 32'h1);
         stepCycle();
      end
      applyStimulus(1, 0, OpBad, 0, 0, 0, 0, 0, 0);
      checkOutput("extended done", {31'h0, flush}, 32'h0);

      // Writebacks retire during squash
      applyStimulus(1, 1, OpLui, 0, 0, 3, 0, 0, 0);
      stepCycle();
      applyStimulus(1, 1, OpLui, 0, 0, 4, 0, 0, 0);
      stepCycle();
      applyStimulus(1, 0, OpBad, 0, 0, 0, 0, 0, 1);
      stepCycle();
      applyStimulus(1, 0, OpBad, 0, 0, 0, 1, 3, 0);
      stepCycle();
      applyStimulus(1, 0, OpBad, 0, 0, 0, 1, 4, 0);
      stepCycle();
      checkOutput("squash retire map", busy_map, 32'h0);

      // Reset mid-squash with pending bits
      for (int r = 4; r < 8; r++) begin
         applyStimulus(1, 1, OpLui, 0, 0, r, 0, 0, 0);
         stepCycle();
      end
      applyStimulus(1, 0, OpBad, 0, 0, 0, 0, 0, 1);
      stepCycle();
      checkOutput("pre-reset map", busy_map, 32'h0F0);
      applyStimulus(0, 1, OpR, 1, 2, 3, 0, 0, 1);
      checkOutput("reset flush low", {31'h0, flush}, 32'h0);
      checkOutput("reset issue low", {31'h0, issue}, 32'h0);
      stepCycle();
      checkOutput("reset map clear", busy_map, 32'h0);
      applyStimulus(1, 0, OpBad, 0, 0, 0, 0, 0, 0);
      checkOutput("reset state run", {31'h0, flush}, 32'h0);
      stepCycle();

      // Random traffic over a small register window to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         logic [6:0] op;
         int sel;
         sel = $urandom_range(0, 9);
         case (sel)
            0: op = OpR;   1: op = OpS;   2: op = OpB;   3: op = OpI;
            4: op = OpLd;  5: op = OpJlr; 6: op = OpLui; 7: op = OpAui;
            8: op = OpJal; default: op = 7'($urandom_range(0, 127));
         endcase
         applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), op,
                       $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 1), $urandom_range(0, 7),
                       ($urandom_range(0, 11) == 0));
         stepCycle();
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
